dvp_pattern_gen: RTL

DVP_PATTERN_GEN -- requirements
Module: dvp_pattern_gen

---
 rtl/dvp_pattern_gen_pkg.sv | 26 ++
 rtl/dvp_pattern_lut.sv | 31 +++
 rtl/dvp_pattern_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dvp_pattern_gen_pkg.sv
// Shared camera package: DVP source FSM encoding, test-pattern codes and a sizing helper.
package dvp_pattern_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } dvp_state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FCNT  = 2'd3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_pattern_lut.sv
// Combinational pixel-value generator: maps (pattern, x, y, frame count) to a 10-bit DVP word.
module dvp_pattern_lut
  import dvp_pattern_gen_pkg::*;
#(
  parameter int BAR_SHIFT = 4
) (
  input  logic [1:0] i_pattern,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [7:0] i_frame_cnt,
  output logic [9:0] o_pixdata
);

  logic [2:0] w_bar;
  logic       w_chk;

  // Pixel value selection for the latched pattern
  always_comb begin
    w_bar     = 3'(i_x >> BAR_SHIFT);
    w_chk     = ((i_x ^ i_y) & 10'h008) != 10'd0;
    o_pixdata = 10'd0;
    case (i_pattern)
      PAT_BARS:  o_pixdata = {w_bar, w_bar, w_bar, 1'b0};
      PAT_RAMP:  o_pixdata = i_x;
      PAT_CHECK: o_pixdata = w_chk ? 10'h3FF : 10'h000;
      PAT_FCNT:  o_pixdata = {2'b00, i_frame_cnt};
      default:   o_pixdata = 10'd0;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_gen.sv
// DVP camera-side test source: VSYNC/HREF/PIXDATA frame timing with selectable test patterns.
module dvp_pattern_gen
  import dvp_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 160,
  parameter int H_BLANK     = 32,
  parameter int V_ACTIVE    = 120,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2,
  parameter int BAR_SHIFT   = 4
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_en,
  input  logic [1:0] I_pattern,
  output logic       O_vsync,
  output logic       O_href,
  output logic [9:0] O_pixdata,
  output logic       O_frame_done,
  output logic       O_busy
);

  localparam int L  = H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(L);
  localparam int VW = $clog2(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT) + 1);

  localparam logic [HW-1:0] H_LAST       = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] V_BACK_LAST  = VW'(V_BACK - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_FRONT_LAST = VW'(V_FRONT - 1);

  dvp_state_e      r_state;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic [1:0]      r_pat;
  logic [7:0]      r_fcnt;
  logic            r_vsync;
  logic            r_href;
  logic [9:0]      r_pix;
  logic            r_done;
  logic            r_busy;

  dvp_state_e      w_state_nxt;
  logic [HW-1:0]   w_h_nxt;
  logic [VW-1:0]   w_v_nxt;
  logic [VW-1:0]   w_v_last;
  logic [1:0]      w_pat_nxt;
  logic [7:0]      w_fcnt_nxt;
  logic            w_href_nxt;
  logic            w_done_nxt;
  logic [9:0]      w_x;
  logic [9:0]      w_y;
  logic [9:0]      w_pix_lut;

  // Next beat position; outputs are registered from it so they track the state with no lag
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = {HW{1'b0}};
    w_v_nxt     = {VW{1'b0}};
    case (r_state)
      ST_VSYNC:  w_v_last = V_SYNC_LAST;
      ST_VBACK:  w_v_last = V_BACK_LAST;
      ST_ACTIVE: w_v_last = V_ACT_LAST;
      ST_VFRONT: w_v_last = V_FRONT_LAST;
      default:   w_v_last = {VW{1'b0}};
    endcase

    if (r_state == ST_IDLE) begin
      w_state_nxt = I_en ? ST_VSYNC : ST_IDLE;
    end else if (r_h != H_LAST) begin
      w_h_nxt = r_h + HW'(1);
      w_v_nxt = r_v;
    end else if (r_v != w_v_last) begin
      w_v_nxt = r_v + VW'(1);
    end else begin
      case (r_state)
        ST_VSYNC:  w_state_nxt = ST_VBACK;
        ST_VBACK:  w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: w_state_nxt = ST_VFRONT;
        ST_VFRONT: w_state_nxt = I_en ? ST_VSYNC : ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end

    // Pattern is captured only on entry to VSYNC so a frame never changes pattern mid-way
    if ((w_state_nxt == ST_VSYNC) && (r_state != ST_VSYNC)) begin
      w_pat_nxt = I_pattern;
    end else begin
      w_pat_nxt = r_pat;
    end

    w_done_nxt = (w_state_nxt == ST_VFRONT) && (w_h_nxt == H_LAST) && (w_v_nxt == V_FRONT_LAST);
    w_href_nxt = (w_state_nxt == ST_ACTIVE) && (w_h_nxt < H_ACT_END);
    if (w_done_nxt) begin
      w_fcnt_nxt = r_fcnt + 8'd1;
    end else begin
      w_fcnt_nxt = r_fcnt;
    end
    w_x = 10'(w_h_nxt);
    w_y = 10'(w_v_nxt);
  end

  dvp_pattern_lut #(
    .BAR_SHIFT (BAR_SHIFT)
  ) u_lut (
    .i_pattern   (w_pat_nxt),
    .i_x         (w_x),
    .i_y         (w_y),
    .i_frame_cnt (w_fcnt_nxt),
    .o_pixdata   (w_pix_lut)
  );

  // Frame FSM, counters, latched pattern and registered DVP outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= ST_IDLE;
      r_h     <= {HW{1'b0}};
      r_v     <= {VW{1'b0}};
      r_pat   <= 2'd0;
      r_fcnt  <= 8'd0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_pix   <= 10'd0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_pat   <= w_pat_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_vsync <= (w_state_nxt == ST_VSYNC);
      r_href  <= w_href_nxt;
      r_pix   <= w_href_nxt ? w_pix_lut : 10'd0;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign O_vsync      = r_vsync;
  assign O_href       = r_href;
  assign O_pixdata    = r_pix;
  assign O_frame_done = r_done;
  assign O_busy       = r_busy;

endmodule
